// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
//   in_valid/in_ready : operand beat handshake (a, b, cin, sub travel with it)
//   out_valid/out_ready : result handshake (sum, cout, ovf travel with it)
// master: the producer/consumer side (testbench or surrounding datapath).
// slave : the adder itself.
interface pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit add/subtract unit.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, flushes every in-flight beat
//   bus  : pipe_adder_if.slave carrying operands (a, b, cin, sub) with
//          in_valid/in_ready and results (sum, cout, ovf) with
//          out_valid/out_ready.
// The carry chain is split into STAGES segments of CHUNK bits. Segment k adds
// chunk k using the carry registered by segment k-1; operands and the partial
// sum ride along with the beat so every chunk reaches the last register
// together. The last segment register is the output register, so a beat
// accepted at edge t is presented after edge t+STAGES-1.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic          clk,
  input  logic          rst,
  pipe_adder_if.slave   bus
);
  localparam int CHUNK = WIDTH / STAGES;

  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  bp_q  [STAGES];
  logic [WIDTH-1:0]  bp_d  [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] carry_d;
  logic              ovf_q;
  logic              ovf_d;

  logic              advance_s;
  logic [WIDTH-1:0]  a_src_s;
  logic [WIDTH-1:0]  b_src_s;
  logic [WIDTH-1:0]  s_src_s;
  logic              c_src_s;
  logic              v_src_s;
  logic [CHUNK:0]    chunk_s;

  // Segment adders and next-state for every pipeline register.
  always_comb begin
    // The whole pipeline moves as one unit unless the output is held.
    advance_s = bus.out_ready | ~valid_q[STAGES-1];
    // Segment 0 sources: effective operands; subtract is A + ~B + ~cin.
    a_src_s   = bus.a;
    b_src_s   = bus.sub ? ~bus.b : bus.b;
    c_src_s   = bus.sub ? ~bus.cin : bus.cin;
    s_src_s   = {WIDTH{1'b0}};
    v_src_s   = bus.in_valid;
    chunk_s   = {(CHUNK+1){1'b0}};
    ovf_d     = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      chunk_s = {1'b0, a_src_s[k*CHUNK +: CHUNK]}
              + {1'b0, b_src_s[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c_src_s};
      a_d[k]                      = a_src_s;
      bp_d[k]                     = b_src_s;
      sum_d[k]                    = s_src_s;
      sum_d[k][k*CHUNK +: CHUNK]  = chunk_s[CHUNK-1:0];
      carry_d[k]                  = chunk_s[CHUNK];
      valid_d[k]                  = v_src_s;
      // Carry into the MSB is recovered as sum ^ a ^ b at that bit. Every
      // iteration overwrites this; only the last segment (which holds the
      // MSB) survives.
      ovf_d = chunk_s[CHUNK] ^ chunk_s[CHUNK-1]
            ^ a_src_s[WIDTH-1] ^ b_src_s[WIDTH-1];
      // Next segment consumes what this segment registered.
      a_src_s = a_q[k];
      b_src_s = bp_q[k];
      s_src_s = sum_q[k];
      c_src_s = carry_q[k];
      v_src_s = valid_q[k];
    end
  end

  // Pipeline registers: flush on reset, advance together, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= {WIDTH{1'b0}};
        bp_q[k]  <= {WIDTH{1'b0}};
        sum_q[k] <= {WIDTH{1'b0}};
      end
      valid_q <= {STAGES{1'b0}};
      carry_q <= {STAGES{1'b0}};
      ovf_q   <= 1'b0;
    end else if (advance_s) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        bp_q[k]  <= bp_d[k];
        sum_q[k] <= sum_d[k];
      end
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_q[k];
        bp_q[k]  <= bp_q[k];
        sum_q[k] <= sum_q[k];
      end
      valid_q <= valid_q;
      carry_q <= carry_q;
      ovf_q   <= ovf_q;
    end
  end

  assign bus.in_ready  = advance_s;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = carry_q[STAGES-1];
  assign bus.ovf       = ovf_q;
endmodule
